// File: rtl/spi_slave_regfile_if.sv
// SPI bus between one master and one slave endpoint.
// Signals:
//   spi_sclk_in   serial clock, driven by the master
//   spi_mosi_in   master-out serial data, MSB first
//   spi_cs_n_in   active-low chip select for this slave
//   spi_miso_out  slave-out serial data, MSB first
// Modports: master drives SCLK/MOSI/CS_n and reads MISO; slave is the mirror image.
interface spi_slave_regfile_if;
   logic spi_sclk_in;
   logic spi_mosi_in;
   logic spi_cs_n_in;
   logic spi_miso_out;

   modport master (
      output spi_sclk_in,
      output spi_mosi_in,
      output spi_cs_n_in,
      input  spi_miso_out
   );

   modport slave (
      input  spi_sclk_in,
      input  spi_mosi_in,
      input  spi_cs_n_in,
      output spi_miso_out
   );
endinterface

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave backed by a 16-bit register file.
// A frame is 32 bits MSB first: 16-bit command then 16-bit data. cmd[1] selects read (1) or
// write (0); cmd[10:3] is the word address (low ADDR_W bits used). Writes commit on the 32nd
// SCLK rise; reads shift the addressed word out on MISO during the data phase.
// Ports:
//   clk          system clock, the only clock in the block
//   sys_reset    synchronous active-high reset; clears the FSM and the whole register file
//   spi          slave modport of the SPI bus; all inputs are asynchronous and 2-FF synchronised
//   wr_valid     1-clk pulse when an SPI write commits
//   wr_addr      address of the committed write, valid with wr_valid
//   wr_data      data of the committed write, valid with wr_valid
//   frame_err    1-clk pulse when CS deasserts before a frame is complete
//   loc_rd_addr  local read address
//   loc_rd_data  mem[loc_rd_addr], registered, one clk of latency
module spi_slave_regfile #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned MIN_HALF = 4
) (
   input  logic              clk,
   input  logic              sys_reset,
   spi_slave_regfile_if.slave spi,
   output logic              wr_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              frame_err,
   input  logic [ADDR_W-1:0] loc_rd_addr,
   output logic [15:0]       loc_rd_data
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   // The address field is 8 bits wide, and edge detection needs 3 clk per SCLK phase.
   if (ADDR_W < 1 || ADDR_W > 8 || MIN_HALF < 3) begin : g_param_check
      $error("spi_slave_regfile: unsupported ADDR_W or MIN_HALF");
   end

   typedef enum logic [1:0] {StIdle, StCmd, StData, StDone} state_e;

   // ---------------------------------------------------------------- synchronisers
   logic sclk_s1_q, sclk_s2_q, sclk_prev_q;
   logic cs_s1_q, cs_s2_q, cs_prev_q;
   logic mosi_s1_q, mosi_s2_q;
   logic live_q;   // first stage holds real pin data (not reset value)
   logic armed_q;  // CS has genuinely been seen high since reset

   always_ff @(posedge clk) begin
      if (sys_reset) begin
         sclk_s1_q   <= 1'b0;
         sclk_s2_q   <= 1'b0;
         sclk_prev_q <= 1'b0;
         cs_s1_q     <= 1'b1;
         cs_s2_q     <= 1'b1;
         cs_prev_q   <= 1'b1;
         mosi_s1_q   <= 1'b0;
         mosi_s2_q   <= 1'b0;
         live_q      <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         sclk_s1_q   <= spi.spi_sclk_in;
         sclk_s2_q   <= sclk_s1_q;
         sclk_prev_q <= sclk_s2_q;
         cs_s1_q     <= spi.spi_cs_n_in;
         cs_s2_q     <= cs_s1_q;
         cs_prev_q   <= cs_s2_q;
         mosi_s1_q   <= spi.spi_mosi_in;
         mosi_s2_q   <= mosi_s1_q;
         live_q      <= 1'b1;
         // The reset value of the CS chain is high, so only trust it once real data arrived.
         if (live_q && cs_s1_q) begin
            armed_q <= 1'b1;
         end
      end
   end

   logic sclk_rise, sclk_fall, cs_rise, cs_fall;
   assign sclk_rise = sclk_s2_q & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s2_q & sclk_prev_q;
   assign cs_rise   = cs_s2_q & ~cs_prev_q;
   assign cs_fall   = ~cs_s2_q & cs_prev_q;

   // ---------------------------------------------------------------- frame FSM
   state_e            state_q;
   logic [5:0]        bitcnt_q;
   logic [14:0]       shreg_q;   // previous 15 MOSI bits; the current bit completes the word
   logic [ADDR_W-1:0] addr_q;
   logic              rw_q;
   logic [15:0]       rd_shift_q;
   logic              miso_q;
   logic              wr_valid_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [15:0]       wr_data_q;
   logic              frame_err_q;
   logic [15:0]       mem_q [DEPTH];
   logic [15:0]       loc_rd_data_q;

   logic        commit;
   logic [15:0] wdata;
   assign wdata  = {shreg_q, mosi_s2_q};
   assign commit = (state_q == StData) && sclk_rise && !cs_rise && (bitcnt_q == 6'd31) && !rw_q;

   always_ff @(posedge clk) begin
      if (sys_reset) begin
         state_q     <= StIdle;
         bitcnt_q    <= '0;
         shreg_q     <= '0;
         addr_q      <= '0;
         rw_q        <= 1'b0;
         rd_shift_q  <= '0;
         miso_q      <= 1'b0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         frame_err_q <= 1'b0;
      end else begin
         wr_valid_q  <= commit;
         frame_err_q <= 1'b0;
         if (commit) begin
            wr_addr_q <= addr_q;
            wr_data_q <= wdata;
         end
         if (cs_rise) begin
            // Completed frames have already moved to StDone, so only partial ones land here.
            if (state_q == StCmd || state_q == StData) begin
               frame_err_q <= 1'b1;
            end
            state_q  <= StIdle;
            miso_q   <= 1'b0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  bitcnt_q <= '0;
                  shreg_q  <= '0;
                  miso_q   <= 1'b0;
                  if (cs_fall && armed_q) begin
                     state_q <= StCmd;
                  end
               end
               StCmd: begin
                  miso_q <= 1'b0;
                  if (sclk_rise) begin
                     shreg_q  <= {shreg_q[13:0], mosi_s2_q};
                     bitcnt_q <= bitcnt_q + 6'd1;
                     if (bitcnt_q == 6'd15) begin
                        // cmd = {shreg_q, mosi}: cmd[10:3] = shreg_q[9:2], cmd[1] = shreg_q[0]
                        addr_q  <= shreg_q[2 +: ADDR_W];
                        rw_q    <= shreg_q[0];
                        state_q <= StData;
                        if (shreg_q[0]) begin
                           rd_shift_q <= mem_q[shreg_q[2 +: ADDR_W]];
                        end
                     end
                  end
               end
               StData: begin
                  if (sclk_rise) begin
                     shreg_q  <= {shreg_q[13:0], mosi_s2_q};
                     bitcnt_q <= bitcnt_q + 6'd1;
                     if (bitcnt_q == 6'd31) begin
                        state_q <= StDone;
                        miso_q  <= 1'b0;
                     end
                  end else if (sclk_fall && rw_q) begin
                     miso_q     <= rd_shift_q[15];
                     rd_shift_q <= {rd_shift_q[14:0], 1'b0};
                  end
               end
               StDone: begin
                  miso_q <= 1'b0;
               end
               default: begin
                  state_q <= StIdle;
                  miso_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   // ---------------------------------------------------------------- register file
   // Non-blocking update means a same-clk local read sees the old word.
   always_ff @(posedge clk) begin
      if (sys_reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i[ADDR_W-1:0]] <= '0;
         end
         loc_rd_data_q <= '0;
      end else begin
         if (commit) begin
            mem_q[addr_q] <= wdata;
         end
         loc_rd_data_q <= mem_q[loc_rd_addr];
      end
   end

   assign spi.spi_miso_out = miso_q;
   assign wr_valid         = wr_valid_q;
   assign wr_addr          = wr_addr_q;
   assign wr_data          = wr_data_q;
   assign frame_err        = frame_err_q;
   assign loc_rd_data      = loc_rd_data_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: a table of SPI frames driven by a bit-banged master, with
// expected write and error events queued in a scoreboard and checked by a monitor.
module tb_spi_slave_regfile;

   localparam int HALF    = 4;  // SCLK half-period in clk cycles
   localparam int CS_HIGH = 4;  // CS idle time between frames in clk cycles

   logic       clk;
   logic       sys_reset;
   logic       wr_valid;
   logic [7:0] wr_addr;
   logic [15:0] wr_data;
   logic       frame_err;
   logic [7:0] loc_rd_addr;
   logic [15:0] loc_rd_data;

   spi_slave_regfile_if bus ();

   spi_slave_regfile #(
      .ADDR_W   (8),
      .MIN_HALF (HALF)
   ) dut (
      .clk         (clk),
      .sys_reset   (sys_reset),
      .spi         (bus),
      .wr_valid    (wr_valid),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .frame_err   (frame_err),
      .loc_rd_addr (loc_rd_addr),
      .loc_rd_data (loc_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] cmd;
      logic [15:0] data;
      int          nbits;
      int          extra;
      logic        exp_wr;
      logic [7:0]  exp_addr;
      logic        exp_err;
      logic        chk_rd;
      logic [15:0] exp_rd;
   } vec_t;

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] data;
   } wr_exp_t;

   vec_t        vecs [13];
   wr_exp_t     exp_wr_q [$];
   logic        exp_err_q [$];
   logic [15:0] model_mem [256];
   int          n_vec  = 0;
   int          n_miss = 0;
   logic        new_pending = 1'b0;
   logic [15:0] new_val;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic half_wait();
      repeat (HALF) @(negedge clk);
   endtask

   // Bit-bangs one mode-0 frame. MISO is sampled just before each rising SCLK edge.
   task automatic drive_frame(input logic [15:0] cmd, input logic [15:0] data, input int nbits,
                              input int extra, input int rst_bit,
                              output logic [15:0] rd, output logic bad);
      logic [31:0] word;
      word = {cmd, data};
      rd   = '0;
      bad  = 1'b0;
      @(negedge clk);
      bus.spi_cs_n_in = 1'b0;
      bus.spi_sclk_in = 1'b0;
      bus.spi_mosi_in = word[31];
      half_wait();
      for (int i = 0; i < nbits; i++) begin
         if (i >= 16) rd = {rd[14:0], bus.spi_miso_out};
         else if (bus.spi_miso_out !== 1'b0) bad = 1'b1;
         bus.spi_sclk_in = 1'b1;
         for (int c = 0; c < HALF; c++) begin
            if (i == rst_bit) sys_reset = (c < 2);
            @(negedge clk);
         end
         bus.spi_sclk_in = 1'b0;
         if (i < 31) bus.spi_mosi_in = word[30 - i];
         half_wait();
      end
      for (int i = 0; i < extra; i++) begin
         if (bus.spi_miso_out !== 1'b0) bad = 1'b1;
         bus.spi_mosi_in = i[0];
         bus.spi_sclk_in = 1'b1;
         half_wait();
         bus.spi_sclk_in = 1'b0;
         half_wait();
      end
      bus.spi_cs_n_in = 1'b1;
      bus.spi_mosi_in = 1'b0;
      repeat (CS_HIGH) @(negedge clk);
      if (bus.spi_miso_out !== 1'b0) bad = 1'b1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rd;
      logic        bad;

      for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;

      //         cmd       data      nb  ext wr    addr   err   rd    exp_rd
      vecs[0]  = '{16'h00D0, 16'hBEEF, 32, 0,  1'b1, 8'h1A, 1'b0, 1'b0, 16'h0000};
      vecs[1]  = '{16'h00D2, 16'h0000, 32, 0,  1'b0, 8'h00, 1'b0, 1'b1, 16'hBEEF};
      vecs[2]  = '{16'h002A, 16'h0000, 32, 0,  1'b0, 8'h00, 1'b0, 1'b1, 16'h0000};
      vecs[3]  = '{16'h0028, 16'h1234, 20, 0,  1'b0, 8'h00, 1'b1, 1'b0, 16'h0000};
      vecs[4]  = '{16'h002A, 16'h0000, 32, 0,  1'b0, 8'h00, 1'b0, 1'b1, 16'h0000};
      vecs[5]  = '{16'h0028, 16'h5A5A, 32, 0,  1'b1, 8'h05, 1'b0, 1'b0, 16'h0000};
      vecs[6]  = '{16'h002A, 16'h0000, 32, 0,  1'b0, 8'h00, 1'b0, 1'b1, 16'h5A5A};
      vecs[7]  = '{16'hFFFD, 16'h8001, 32, 0,  1'b1, 8'hFF, 1'b0, 1'b0, 16'h0000};
      vecs[8]  = '{16'hFFFF, 16'h0000, 32, 0,  1'b0, 8'h00, 1'b0, 1'b1, 16'h8001};
      vecs[9]  = '{16'h00D2, 16'h0000, 10, 0,  1'b0, 8'h00, 1'b1, 1'b0, 16'h0000};
      vecs[10] = '{16'h00D2, 16'h0000, 32, 0,  1'b0, 8'h00, 1'b0, 1'b1, 16'hBEEF};
      vecs[11] = '{16'h00D0, 16'h0F0F, 32, 40, 1'b1, 8'h1A, 1'b0, 1'b0, 16'h0000};
      vecs[12] = '{16'h00D2, 16'h0000, 32, 0,  1'b0, 8'h00, 1'b0, 1'b1, 16'h0F0F};

      sys_reset       = 1'b1;
      bus.spi_sclk_in = 1'b0;
      bus.spi_mosi_in = 1'b0;
      bus.spi_cs_n_in = 1'b1;
      loc_rd_addr     = 8'h00;

      // Monitor: pops the scoreboard on every wr_valid / frame_err pulse.
      fork
         forever begin
            @(negedge clk);
            if (new_pending) begin
               check("loc_rd_data new value", 32'(loc_rd_data), 32'(new_val));
               new_pending = 1'b0;
            end
            if (!sys_reset && wr_valid === 1'b1) begin
               if (exp_wr_q.size() == 0) begin
                  check("unexpected wr_valid", 32'(wr_valid), 32'd0);
               end else begin
                  wr_exp_t e;
                  e = exp_wr_q.pop_front();
                  check("wr_addr", 32'(wr_addr), 32'(e.addr));
                  check("wr_data", 32'(wr_data), 32'(e.data));
                  if (loc_rd_addr == e.addr) begin
                     check("loc_rd_data old value", 32'(loc_rd_data), 32'(model_mem[e.addr]));
                     new_pending = 1'b1;
                     new_val     = e.data;
                  end
                  model_mem[e.addr] = e.data;
               end
            end
            if (!sys_reset && frame_err === 1'b1) begin
               if (exp_err_q.size() == 0) check("unexpected frame_err", 32'(frame_err), 32'd0);
               else void'(exp_err_q.pop_front());
            end
         end
      join_none

      repeat (3) @(negedge clk);
      sys_reset = 1'b0;
      repeat (4) @(negedge clk);
      check("reset miso",        32'(bus.spi_miso_out), 32'd0);
      check("reset wr_valid",    32'(wr_valid),         32'd0);
      check("reset wr_addr",     32'(wr_addr),          32'd0);
      check("reset wr_data",     32'(wr_data),          32'd0);
      check("reset frame_err",   32'(frame_err),        32'd0);
      check("reset loc_rd_data", 32'(loc_rd_data),      32'd0);

      loc_rd_addr = 8'h1A;
      for (int v = 0; v < 13; v++) begin
         if (vecs[v].exp_wr) exp_wr_q.push_back('{vecs[v].exp_addr, vecs[v].data});
         if (vecs[v].exp_err) exp_err_q.push_back(1'b1);
         drive_frame(vecs[v].cmd, vecs[v].data, vecs[v].nbits, vecs[v].extra, -1, rd, bad);
         check($sformatf("v%0d miso idle", v), 32'(bad), 32'd0);
         if (vecs[v].chk_rd) check($sformatf("v%0d read data", v), 32'(rd), 32'(vecs[v].exp_rd));
         check($sformatf("v%0d scoreboard pending", v),
               32'(exp_wr_q.size() + exp_err_q.size()), 32'd0);
      end

      // Local port readback of the table's final contents.
      loc_rd_addr = 8'hFF;
      @(negedge clk);
      check("loc 0xFF", 32'(loc_rd_data), 32'h8001);
      loc_rd_addr = 8'h05;
      @(negedge clk);
      check("loc 0x05", 32'(loc_rd_data), 32'h5A5A);

      // Reset at bit 24 of a write frame: nothing commits and memory is cleared.
      loc_rd_addr = 8'h1A;
      drive_frame(16'h0028, 16'h1111, 32, 0, 24, rd, bad);
      for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
      check("midreset pending", 32'(exp_wr_q.size() + exp_err_q.size()), 32'd0);
      check("midreset wr_addr", 32'(wr_addr), 32'd0);
      check("midreset wr_data", 32'(wr_data), 32'd0);
      check("midreset loc 0x1A", 32'(loc_rd_data), 32'd0);
      loc_rd_addr = 8'h05;
      @(negedge clk);
      check("midreset loc 0x05", 32'(loc_rd_data), 32'd0);

      // Write FACE then read it straight back.
      exp_wr_q.push_back('{8'h05, 16'hFACE});
      drive_frame(16'h0028, 16'hFACE, 32, 0, -1, rd, bad);
      check("face write pending", 32'(exp_wr_q.size()), 32'd0);
      drive_frame(16'h002A, 16'h0000, 32, 0, -1, rd, bad);
      check("face read data", 32'(rd), 32'hFACE);
      check("face miso idle", 32'(bad), 32'd0);
      loc_rd_addr = 8'hFF;
      @(negedge clk);
      check("post-reset loc 0xFF", 32'(loc_rd_data), 32'd0);

      repeat (4) @(negedge clk);
      check("final scoreboard empty", 32'(exp_wr_q.size() + exp_err_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
